// File: rtl/centroid_pkg.sv
// Shared types and default parameters for the centroid accumulator block.
package centroid_pkg;

   localparam int H_RES_DEF      = 640;
   localparam int V_RES_DEF      = 480;
   localparam int MIN_PIXELS_DEF = 16;
   localparam int DW_DEF         = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_ISSUE = 2'd2,
      ST_WAIT  = 2'd3
   } state_e;

   // Coordinate counter width, never narrower than one bit.
   function automatic int coord_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/centroid_accumulator_if.sv
// Divider / result-formatter side of the centroid accumulator.
interface centroid_accumulator_if #(
   parameter int DW = 32
);

   logic [DW-1:0] x_dividend;
   logic [DW-1:0] y_dividend;
   logic [DW-1:0] divisor;
   logic          x_div_tvalid;
   logic          x_div_tready;
   logic          y_div_tvalid;
   logic          y_div_tready;
   logic          acc_done;
   logic          res_valid;
   logic          no_target;

   modport master (
      output x_dividend, y_dividend, divisor,
      output x_div_tvalid, y_div_tvalid, acc_done, no_target,
      input  x_div_tready, y_div_tready, res_valid
   );

   modport slave (
      input  x_dividend, y_dividend, divisor,
      input  x_div_tvalid, y_div_tvalid, acc_done, no_target,
      output x_div_tready, y_div_tready, res_valid
   );

endinterface

// File: rtl/axis_hold_src.sv
// Single AXI-Stream source holding register: loads a word, keeps it valid
// and stable until the sink accepts it.
module axis_hold_src #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         tready,
   output logic         tvalid,
   output logic [W-1:0] dout
);

   // Capture on load, drop valid the cycle after the handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tvalid <= 1'b0;
         dout   <= '0;
      end else if (load) begin
         tvalid <= 1'b1;
         dout   <= din;
      end else if (tvalid && tready) begin
         tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/centroid_accumulator.sv
// Accumulates hit-pixel coordinates over a frame and issues the two
// centroid divisions (sum_x/count, sum_y/count) to the divider cores.
module centroid_accumulator
   import centroid_pkg::*;
#(
   parameter int H_RES      = H_RES_DEF,
   parameter int V_RES      = V_RES_DEF,
   parameter int MIN_PIXELS = MIN_PIXELS_DEF,
   parameter int DW         = DW_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pix_valid,
   input  logic pix_hit,
   input  logic pix_sof,
   input  logic pix_eol,
   centroid_accumulator_if.master div
);

   localparam int XW = coord_width(H_RES);
   localparam int YW = coord_width(V_RES);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_ACCUM = ST_ACCUM;
   localparam logic [1:0] S_ISSUE = ST_ISSUE;
   localparam logic [1:0] S_WAIT  = ST_WAIT;

   localparam logic [YW-1:0] Y_LAST  = YW'(V_RES - 1);
   localparam logic [DW-1:0] MIN_CNT = DW'(MIN_PIXELS);

   logic [1:0]    state;
   logic [XW-1:0] xc;
   logic [YW-1:0] yc;
   logic [XW-1:0] cur_x;
   logic [YW-1:0] cur_y;
   logic [DW-1:0] sum_x;
   logic [DW-1:0] sum_y;
   logic [DW-1:0] count;
   logic [DW-1:0] nx_sum_x;
   logic [DW-1:0] nx_sum_y;
   logic [DW-1:0] nx_count;
   logic [DW-1:0] divisor_r;
   logic [15:0]   frame_cnt;
   logic          no_target_r;
   logic          accept;
   logic          frame_end;
   logic          issue_load;
   logic          issue_done;
   logic          x_tvalid;
   logic          y_tvalid;
   logic [DW-1:0] x_data;
   logic [DW-1:0] y_data;

   // Unsigned add that sticks at all-ones instead of wrapping.
   function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      logic [DW:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[DW] ? {DW{1'b1}} : s[DW-1:0];
   endfunction

   // A start-of-frame beat counts as (0,0) and starts the sums afresh.
   always_comb begin
      cur_x      = pix_sof ? '0 : xc;
      cur_y      = pix_sof ? '0 : yc;
      nx_sum_x   = sat_add(pix_sof ? '0 : sum_x, pix_hit ? DW'(cur_x) : '0);
      nx_sum_y   = sat_add(pix_sof ? '0 : sum_y, pix_hit ? DW'(cur_y) : '0);
      nx_count   = sat_add(pix_sof ? '0 : count, pix_hit ? DW'(1) : '0);
      accept     = pix_valid && (((state == S_IDLE) && pix_sof) || (state == S_ACCUM));
      frame_end  = accept && pix_eol && (cur_y == Y_LAST);
      issue_load = frame_end && (nx_count >= MIN_CNT);
      issue_done = (!x_tvalid || div.x_div_tready) && (!y_tvalid || div.y_div_tready);
   end

   // Raster position tracking runs on every beat regardless of state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xc <= '0;
         yc <= '0;
      end else if (pix_valid) begin
         if (pix_eol) begin
            xc <= '0;
            yc <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
         end else begin
            xc <= cur_x + 1'b1;
            yc <= cur_y;
         end
      end
   end

   // Frame accumulation and issue/wait sequencing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         sum_x       <= '0;
         sum_y       <= '0;
         count       <= '0;
         divisor_r   <= '0;
         no_target_r <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         no_target_r <= 1'b0;
         case (state)
            S_IDLE, S_ACCUM: begin
               if (accept) begin
                  sum_x <= nx_sum_x;
                  sum_y <= nx_sum_y;
                  count <= nx_count;
                  if (frame_end) begin
                     frame_cnt <= frame_cnt + 1'b1;
                     if (issue_load) begin
                        state     <= S_ISSUE;
                        divisor_r <= nx_count;
                     end else begin
                        state       <= S_IDLE;
                        no_target_r <= 1'b1;
                     end
                  end else begin
                     state <= S_ACCUM;
                  end
               end
            end
            S_ISSUE: begin
               if (issue_done) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (div.res_valid) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   axis_hold_src #(.W(DW)) x_src (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (issue_load),
      .din    (nx_sum_x),
      .tready (div.x_div_tready),
      .tvalid (x_tvalid),
      .dout   (x_data)
   );

   axis_hold_src #(.W(DW)) y_src (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (issue_load),
      .din    (nx_sum_y),
      .tready (div.y_div_tready),
      .tvalid (y_tvalid),
      .dout   (y_data)
   );

   assign div.x_dividend   = x_data;
   assign div.y_dividend   = y_data;
   assign div.divisor      = divisor_r;
   assign div.x_div_tvalid = x_tvalid;
   assign div.y_div_tvalid = y_tvalid;
   assign div.acc_done     = (state == S_ISSUE) || (state == S_WAIT);
   assign div.no_target    = no_target_r;

endmodule

// File: tb/tb_centroid_accumulator.sv
// Directed bench for centroid_accumulator on a reduced 64x48 raster.
module tb_centroid_accumulator;

   localparam int H    = 64;
   localparam int V    = 48;
   localparam int MINP = 2;
   localparam int DW   = 32;

   typedef struct packed {
      logic            full;
      logic [2:0]      nh;
      logic [3:0][7:0] hx;
      logic [3:0][7:0] hy;
      logic            exp_issue;
      logic [31:0]     exp_x;
      logic [31:0]     exp_y;
      logic [31:0]     exp_cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pix_valid = 1'b0;
   logic pix_hit = 1'b0;
   logic pix_sof = 1'b0;
   logic pix_eol = 1'b0;

   int total = 0;
   int passed = 0;
   int nt_count = 0;
   bit cur_full;
   int cur_nh;
   int cur_hx[4];
   int cur_hy[4];
   vec_t vecs[6];

   centroid_accumulator_if #(.DW(DW)) div_if ();

   centroid_accumulator #(
      .H_RES(H), .V_RES(V), .MIN_PIXELS(MINP), .DW(DW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pix_valid (pix_valid),
      .pix_hit   (pix_hit),
      .pix_sof   (pix_sof),
      .pix_eol   (pix_eol),
      .div       (div_if)
   );

   always #5 clk = ~clk;

   // Count no_target pulses so stray or stretched pulses are visible.
   always @(posedge clk) begin
      if (div_if.no_target === 1'b1) nt_count++;
   end

   function automatic vec_t make_vec(bit full, int nh, int x0, int y0, int x1, int y1,
                                     int x2, int y2, int x3, int y3, bit issue,
                                     int ex, int ey, int ec);
      vec_t v;
      v.full = full; v.nh = 3'(nh);
      v.hx[0] = 8'(x0); v.hy[0] = 8'(y0); v.hx[1] = 8'(x1); v.hy[1] = 8'(y1);
      v.hx[2] = 8'(x2); v.hy[2] = 8'(y2); v.hx[3] = 8'(x3); v.hy[3] = 8'(y3);
      v.exp_issue = issue; v.exp_x = ex; v.exp_y = ey; v.exp_cnt = ec;
      return v;
   endfunction

   function automatic bit is_hit(int x, int y);
      if (cur_full) return 1'b1;
      for (int i = 0; i < cur_nh; i++)
         if (cur_hx[i] == x && cur_hy[i] == y) return 1'b1;
      return 1'b0;
   endfunction

   task automatic load_hits(vec_t v);
      cur_full = v.full;
      cur_nh = int'(v.nh);
      for (int i = 0; i < 4; i++) begin
         cur_hx[i] = int'(v.hx[i]);
         cur_hy[i] = int'(v.hy[i]);
      end
   endtask

   task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      else
         passed++;
   endtask

   // Drives n_lines full lines starting with a start-of-frame beat; returns at
   // the negedge after the last beat, i.e. one cycle after it was sampled.
   task automatic send_lines(int n_lines);
      for (int y = 0; y < n_lines; y++) begin
         for (int x = 0; x < H; x++) begin
            pix_valid = 1'b1;
            pix_sof = (x == 0 && y == 0);
            pix_eol = (x == H - 1);
            pix_hit = is_hit(x, y);
            @(negedge clk);
         end
      end
      pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0; pix_hit = 1'b0;
   endtask

   // One complete frame with both dividers ready, checked through to IDLE.
   task automatic apply_stimulus(vec_t v, string tag);
      int nt_before;
      load_hits(v);
      div_if.x_div_tready = 1'b1;
      div_if.y_div_tready = 1'b1;
      nt_before = nt_count;
      send_lines(V);
      if (v.exp_issue) begin
         check_output({tag, " x_tvalid@N+1"}, 32'(div_if.x_div_tvalid), 1);
         check_output({tag, " y_tvalid@N+1"}, 32'(div_if.y_div_tvalid), 1);
         check_output({tag, " acc_done@N+1"}, 32'(div_if.acc_done), 1);
         check_output({tag, " x_dividend"}, div_if.x_dividend, v.exp_x);
         check_output({tag, " y_dividend"}, div_if.y_dividend, v.exp_y);
         check_output({tag, " divisor"}, div_if.divisor, v.exp_cnt);
         @(negedge clk);
         check_output({tag, " tvalid@N+2"}, 32'({div_if.x_div_tvalid, div_if.y_div_tvalid}), 0);
         check_output({tag, " acc_done@N+2"}, 32'(div_if.acc_done), 1);
         div_if.res_valid = 1'b1;
         @(negedge clk);
         div_if.res_valid = 1'b0;
         check_output({tag, " acc_done@M+1"}, 32'(div_if.acc_done), 0);
      end else begin
         check_output({tag, " no_target@N+1"}, 32'(div_if.no_target), 1);
         check_output({tag, " tvalid@N+1"}, 32'({div_if.x_div_tvalid, div_if.y_div_tvalid}), 0);
         check_output({tag, " acc_done@N+1"}, 32'(div_if.acc_done), 0);
         @(negedge clk);
         check_output({tag, " no_target@N+2"}, 32'(div_if.no_target), 0);
         check_output({tag, " pulse count"}, nt_count - nt_before, 1);
      end
   endtask

   initial begin
      int nt_before;
      vecs[0] = make_vec(0, 2, 10, 20, 30, 40, 0, 0, 0, 0, 1, 40, 60, 2);
      vecs[1] = make_vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 96768, 72192, 3072);
      vecs[2] = make_vec(0, 1, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[3] = make_vec(0, 2, 0, 0, 63, 47, 0, 0, 0, 0, 1, 63, 47, 2);
      vecs[4] = make_vec(0, 4, 1, 1, 2, 2, 3, 3, 63, 0, 1, 69, 6, 4);
      vecs[5] = make_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      div_if.x_div_tready = 1'b0;
      div_if.y_div_tready = 1'b0;
      div_if.res_valid = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk);
      check_output("reset outputs", 32'({div_if.x_div_tvalid, div_if.y_div_tvalid,
                   div_if.acc_done, div_if.no_target}), 0);
      check_output("reset x_dividend", div_if.x_dividend, 0);
      check_output("reset divisor", div_if.divisor, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table of whole frames.
      for (int i = 0; i < 6; i++)
         apply_stimulus(vecs[i], $sformatf("vec%0d", i));

      // y divider back-pressure, a dropped sof beat and an early res_valid.
      $display("[TB] y back-pressure sequence");
      load_hits(vecs[0]);
      div_if.x_div_tready = 1'b1;
      div_if.y_div_tready = 1'b0;
      send_lines(V);
      check_output("bp tvalid@N+1", 32'({div_if.x_div_tvalid, div_if.y_div_tvalid}), 3);
      @(negedge clk);
      check_output("bp x_tvalid@N+2", 32'(div_if.x_div_tvalid), 0);
      check_output("bp y_tvalid@N+2", 32'(div_if.y_div_tvalid), 1);
      check_output("bp x_dividend@N+2", div_if.x_dividend, 40);
      pix_valid = 1'b1; pix_sof = 1'b1; pix_hit = 1'b1;
      @(negedge clk);
      pix_valid = 1'b0; pix_sof = 1'b0; pix_hit = 1'b0;
      check_output("bp y_tvalid@N+3", 32'(div_if.y_div_tvalid), 1);
      div_if.res_valid = 1'b1;
      @(negedge clk);
      div_if.res_valid = 1'b0;
      check_output("bp acc_done@N+4", 32'(div_if.acc_done), 1);
      check_output("bp y_tvalid@N+4", 32'(div_if.y_div_tvalid), 1);
      check_output("bp y_dividend@N+4", div_if.y_dividend, 60);
      check_output("bp divisor@N+4", div_if.divisor, 2);
      @(negedge clk);
      check_output("bp y_tvalid@N+5", 32'(div_if.y_div_tvalid), 1);
      div_if.y_div_tready = 1'b1;
      @(negedge clk);
      check_output("bp y_tvalid@N+6", 32'(div_if.y_div_tvalid), 0);
      check_output("bp acc_done@N+6", 32'(div_if.acc_done), 1);
      check_output("bp y_dividend@N+6", div_if.y_dividend, 60);
      div_if.res_valid = 1'b1;
      @(negedge clk);
      div_if.res_valid = 1'b0;
      check_output("bp acc_done after res", 32'(div_if.acc_done), 0);

      // Restart: a new sof at line 30 discards the partial frame.
      $display("[TB] mid-frame restart sequence");
      nt_before = nt_count;
      load_hits(make_vec(0, 2, 5, 5, 7, 10, 0, 0, 0, 0, 0, 0, 0, 0));
      send_lines(30);
      check_output("restart acc_done mid", 32'(div_if.acc_done), 0);
      apply_stimulus(make_vec(0, 2, 2, 3, 4, 5, 0, 0, 0, 0, 1, 6, 8, 2), "restart");
      check_output("restart no pulse", nt_count - nt_before, 0);

      // Reset while issuing.
      $display("[TB] reset in ISSUE sequence");
      load_hits(vecs[0]);
      div_if.x_div_tready = 1'b0;
      div_if.y_div_tready = 1'b0;
      send_lines(V);
      check_output("rst-issue tvalid@N+1", 32'({div_if.x_div_tvalid, div_if.y_div_tvalid}), 3);
      #2 rst_n = 1'b0;
      #1;
      check_output("rst-issue flags", 32'({div_if.x_div_tvalid, div_if.y_div_tvalid,
                   div_if.acc_done}), 0);
      check_output("rst-issue x_dividend", div_if.x_dividend, 0);
      check_output("rst-issue divisor", div_if.divisor, 0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(make_vec(0, 2, 1, 2, 3, 4, 0, 0, 0, 0, 1, 4, 6, 2), "post-rst1");

      // Reset while waiting for the formatter.
      $display("[TB] reset in WAIT sequence");
      load_hits(vecs[0]);
      send_lines(V);
      @(negedge clk);
      check_output("rst-wait acc_done@N+2", 32'(div_if.acc_done), 1);
      #2 rst_n = 1'b0;
      #1;
      check_output("rst-wait acc_done", 32'(div_if.acc_done), 0);
      check_output("rst-wait y_dividend", div_if.y_dividend, 0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(make_vec(0, 2, 7, 9, 8, 1, 0, 0, 0, 0, 1, 15, 10, 2), "post-rst2");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
